// File: rtl/lookup_arbiter.sv
// rtl/lookup_arbiter.sv - round-robin arbiter sharing one MAC lookup engine among four requesters
// Tags each issue with the requester index, caps outstanding lookups and routes results back by id.
module lookup_arbiter #(
    parameter int P_REQ_NUM      = 4,
    parameter int P_MAX_INFLIGHT = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_enable,
    input  logic         i_pause,
    output logic         o_paused,
    input  logic [3:0]   i_req_valid,
    input  logic [191:0] i_req_mac,
    input  logic [7:0]   i_req_tag,
    output logic [3:0]   o_req_ready,
    output logic [47:0]  o_check_mac,
    output logic [3:0]   o_check_id,
    output logic         o_check_valid,
    input  logic         i_result_valid,
    input  logic [3:0]   i_check_id,
    input  logic [2:0]   i_outport,
    input  logic [1:0]   i_seek_flag,
    output logic [3:0]   o_rsp_valid,
    output logic [11:0]  o_rsp_outport,
    output logic [7:0]   o_rsp_seek_flag,
    output logic [7:0]   o_rsp_tag,
    output logic [2:0]   o_inflight,
    output logic         o_err_orphan
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_PAUSED} state_t;

    localparam logic [3:0] MAX_W = 4'(P_MAX_INFLIGHT);

    state_t     state;
    logic [1:0] rr_ptr;
    logic [1:0] grant_idx;
    logic [1:0] scan_idx;
    logic       grant_any;
    logic       can_issue;
    logic [1:0] rsp_idx;

    // The pending issue in o_check_valid is not yet counted in o_inflight, so it consumes a credit too.
    always_comb begin
        o_req_ready = '0;
        grant_idx   = rr_ptr;
        grant_any   = 1'b0;
        scan_idx    = rr_ptr;
        can_issue   = (state == S_RUN) && !i_pause &&
                      (({1'b0, o_inflight} + {3'b000, o_check_valid}) < MAX_W);
        if (can_issue) begin
            for (int i = 0; i < P_REQ_NUM; i++) begin
                scan_idx = rr_ptr + 2'(i);
                if (!grant_any && i_req_valid[scan_idx]) begin
                    grant_any = 1'b1;
                    grant_idx = scan_idx;
                end
            end
        end
        if (grant_any) begin
            o_req_ready[grant_idx] = 1'b1;
        end
    end

    assign rsp_idx = i_check_id[3:2];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= S_IDLE;
            o_paused        <= 1'b0;
            rr_ptr          <= '0;
            o_check_valid   <= 1'b0;
            o_check_mac     <= '0;
            o_check_id      <= '0;
            o_inflight      <= '0;
            o_err_orphan    <= 1'b0;
            o_rsp_valid     <= '0;
            o_rsp_outport   <= '0;
            o_rsp_seek_flag <= '0;
            o_rsp_tag       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_enable) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (i_pause) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!i_pause) begin
                        state <= S_RUN;
                    end else if (o_inflight == 3'd0 && !o_check_valid) begin
                        state    <= S_PAUSED;
                        o_paused <= 1'b1;
                    end
                end
                S_PAUSED: begin
                    if (!i_pause) begin
                        state    <= S_RUN;
                        o_paused <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    o_paused <= 1'b0;
                end
            endcase

            o_check_valid <= grant_any;
            if (grant_any) begin
                rr_ptr      <= grant_idx + 2'd1;
                o_check_mac <= i_req_mac[grant_idx*48 +: 48];
                o_check_id  <= {grant_idx, i_req_tag[grant_idx*2 +: 2]};
            end

            case ({o_check_valid, i_result_valid})
                2'b10:   o_inflight <= o_inflight + 3'd1;
                2'b01:   if (o_inflight != 3'd0) o_inflight <= o_inflight - 3'd1;
                default: o_inflight <= o_inflight;
            endcase
            if (i_result_valid && o_inflight == 3'd0) begin
                o_err_orphan <= 1'b1;
            end

            // Results are delivered in any state so a drain can always complete.
            o_rsp_valid <= '0;
            if (i_result_valid) begin
                o_rsp_valid[rsp_idx]               <= 1'b1;
                o_rsp_outport[rsp_idx*3 +: 3]      <= i_outport;
                o_rsp_seek_flag[rsp_idx*2 +: 2]    <= i_seek_flag;
                o_rsp_tag[rsp_idx*2 +: 2]          <= i_check_id[1:0];
            end
        end
    end

endmodule

// File: tb/tb_lookup_arbiter.sv
// tb/tb_lookup_arbiter.sv - directed self-checking bench for lookup_arbiter
// Instance a uses a 2-cycle engine model and the default cap; instance b has a cap of 2 and manual results.
module tb_lookup_arbiter;

    logic         i_clk;
    logic         i_rst;
    logic         i_enable;
    logic         i_pause;
    logic [3:0]   i_req_valid;
    logic [191:0] i_req_mac;
    logic [7:0]   i_req_tag;

    logic        man_valid;
    logic [3:0]  man_id;
    logic [2:0]  man_outport;
    logic [1:0]  man_seek;
    logic        auto_eng;

    logic        p1_v, p2_v;
    logic [3:0]  p1_id, p2_id;

    logic        res_valid_a;
    logic [3:0]  res_id_a;
    logic [2:0]  res_outport_a;
    logic [1:0]  res_seek_a;

    logic        paused_a, paused_b;
    logic [3:0]  ready_a, ready_b;
    logic [47:0] cmac_a, cmac_b;
    logic [3:0]  cid_a, cid_b;
    logic        cv_a, cv_b;
    logic [3:0]  rspv_a, rspv_b;
    logic [11:0] rspo_a, rspo_b;
    logic [7:0]  rsps_a, rsps_b;
    logic [7:0]  rspt_a, rspt_b;
    logic [2:0]  infl_a, infl_b;
    logic        orph_a, orph_b;

    int n_checks;
    int n_fail;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Engine model: result two cycles after issue, outport = id[2:0], seek = id[1:0].
    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            p1_v <= 1'b0; p2_v <= 1'b0; p1_id <= '0; p2_id <= '0;
        end else begin
            p1_v <= cv_a & auto_eng; p1_id <= cid_a;
            p2_v <= p1_v;            p2_id <= p1_id;
        end
    end

    assign res_valid_a   = auto_eng ? p2_v        : man_valid;
    assign res_id_a      = auto_eng ? p2_id       : man_id;
    assign res_outport_a = auto_eng ? p2_id[2:0]  : man_outport;
    assign res_seek_a    = auto_eng ? p2_id[1:0]  : man_seek;

    lookup_arbiter #(.P_REQ_NUM(4), .P_MAX_INFLIGHT(4)) dut_a (
        .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_pause(i_pause), .o_paused(paused_a),
        .i_req_valid(i_req_valid), .i_req_mac(i_req_mac), .i_req_tag(i_req_tag), .o_req_ready(ready_a),
        .o_check_mac(cmac_a), .o_check_id(cid_a), .o_check_valid(cv_a),
        .i_result_valid(res_valid_a), .i_check_id(res_id_a), .i_outport(res_outport_a), .i_seek_flag(res_seek_a),
        .o_rsp_valid(rspv_a), .o_rsp_outport(rspo_a), .o_rsp_seek_flag(rsps_a), .o_rsp_tag(rspt_a),
        .o_inflight(infl_a), .o_err_orphan(orph_a)
    );

    lookup_arbiter #(.P_REQ_NUM(4), .P_MAX_INFLIGHT(2)) dut_b (
        .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_pause(i_pause), .o_paused(paused_b),
        .i_req_valid(i_req_valid), .i_req_mac(i_req_mac), .i_req_tag(i_req_tag), .o_req_ready(ready_b),
        .o_check_mac(cmac_b), .o_check_id(cid_b), .o_check_valid(cv_b),
        .i_result_valid(man_valid), .i_check_id(man_id), .i_outport(man_outport), .i_seek_flag(man_seek),
        .o_rsp_valid(rspv_b), .o_rsp_outport(rspo_b), .o_rsp_seek_flag(rsps_b), .o_rsp_tag(rspt_b),
        .o_inflight(infl_b), .o_err_orphan(orph_b)
    );

    // Leaves the DUTs in S_RUN at a falling edge; callers drive their first vector right after.
    task automatic do_reset(input logic use_eng);
        auto_eng = use_eng;
        i_rst = 1'b1; i_enable = 1'b0; i_pause = 1'b0; i_req_valid = '0;
        man_valid = 1'b0; man_id = '0; man_outport = '0; man_seek = '0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        i_enable = 1'b1;
        @(negedge i_clk);
        i_enable = 1'b0;
    endtask

    task automatic test_reset;
        auto_eng = 1'b1;
        i_rst = 1'b1; i_enable = 1'b0; i_pause = 1'b0; i_req_valid = 4'b1111;
        man_valid = 1'b0; man_id = '0; man_outport = '0; man_seek = '0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        #1;
        n_checks++; if (ready_a !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b expected 0000", ready_a); end
        n_checks++; if (cv_a !== 1'b0) begin n_fail++; $display("FAIL reset_check_valid got %b expected 0", cv_a); end
        n_checks++; if (paused_a !== 1'b0) begin n_fail++; $display("FAIL reset_paused got %b expected 0", paused_a); end
        n_checks++; if (infl_a !== 3'd0) begin n_fail++; $display("FAIL reset_inflight got %0d expected 0", infl_a); end
        n_checks++; if (orph_a !== 1'b0) begin n_fail++; $display("FAIL reset_orphan got %b expected 0", orph_a); end
        n_checks++; if ({rspv_a, rspo_a, cmac_a, cid_a} !== '0) begin n_fail++; $display("FAIL reset_outputs got %h expected 0", {rspv_a, rspo_a, cmac_a, cid_a}); end
        i_req_valid = '0;
    endtask

    task automatic test_single;
        do_reset(1'b1);
        i_req_mac = '0;
        i_req_mac[2*48 +: 48] = 48'h8DBC5C4A0102;
        i_req_tag = 8'b00_01_00_00;
        i_req_valid = 4'b0100;
        #1;
        n_checks++; if (ready_a !== 4'b0100) begin n_fail++; $display("FAIL single_ready got %b expected 0100", ready_a); end
        @(negedge i_clk);
        i_req_valid = '0;
        #1;
        n_checks++; if (cv_a !== 1'b1) begin n_fail++; $display("FAIL single_check_valid got %b expected 1", cv_a); end
        n_checks++; if (cid_a !== 4'b1001) begin n_fail++; $display("FAIL single_check_id got %b expected 1001", cid_a); end
        n_checks++; if (cmac_a !== 48'h8DBC5C4A0102) begin n_fail++; $display("FAIL single_check_mac got %h expected 8dbc5c4a0102", cmac_a); end
        repeat (3) @(negedge i_clk);
        #1;
        n_checks++; if (rspv_a !== 4'b0100) begin n_fail++; $display("FAIL single_rsp_valid got %b expected 0100", rspv_a); end
        n_checks++; if (rspo_a[8:6] !== 3'd1) begin n_fail++; $display("FAIL single_rsp_outport got %0d expected 1", rspo_a[8:6]); end
        n_checks++; if (rsps_a[5:4] !== 2'd1) begin n_fail++; $display("FAIL single_rsp_seek got %0d expected 1", rsps_a[5:4]); end
        n_checks++; if (rspt_a[5:4] !== 2'd1) begin n_fail++; $display("FAIL single_rsp_tag got %0d expected 1", rspt_a[5:4]); end
        @(negedge i_clk);
        #1;
        n_checks++; if (rspv_a !== 4'b0000) begin n_fail++; $display("FAIL single_rsp_pulse got %b expected 0000", rspv_a); end
    endtask

    task automatic test_fairness;
        int cnt [4];
        logic [3:0] exp_rdy;
        for (int k = 0; k < 4; k++) cnt[k] = 0;
        do_reset(1'b1);
        i_req_mac = {48'h444444444444, 48'h333333333333, 48'h222222222222, 48'h111111111111};
        i_req_tag = 8'b11_10_01_00;
        i_req_valid = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            if (c != 0) @(negedge i_clk);
            #1;
            exp_rdy = 4'b0001 << (c % 4);
            n_checks++; if (ready_a !== exp_rdy) begin n_fail++; $display("FAIL fair_ready c=%0d got %b expected %b", c, ready_a, exp_rdy); end
            for (int k = 0; k < 4; k++) if (ready_a[k]) cnt[k]++;
            if (c >= 4) begin
                n_checks++; if (infl_a !== 3'd2) begin n_fail++; $display("FAIL steady_inflight c=%0d got %0d expected 2", c, infl_a); end
            end
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (cnt[k] != 10) begin n_fail++; $display("FAIL fair_share req%0d got %0d expected 10", k, cnt[k]); end
        end
        @(negedge i_clk);
        i_req_valid = '0;
    endtask

    task automatic test_credit;
        int issues;
        do_reset(1'b0);
        i_req_mac = {48'h0, 48'h0, 48'h0, 48'hA0A0A0A0A0A0};
        i_req_tag = '0;
        i_req_valid = 4'b0001;
        issues = 0;
        #1;
        n_checks++; if (ready_b !== 4'b0001) begin n_fail++; $display("FAIL credit_first_ready got %b expected 0001", ready_b); end
        for (int c = 1; c <= 3; c++) begin
            @(negedge i_clk);
            #1;
            if (cv_b) issues++;
            if (c >= 2) begin
                n_checks++; if (ready_b !== 4'b0000) begin n_fail++; $display("FAIL credit_capped c=%0d got %b expected 0000", c, ready_b); end
            end
        end
        n_checks++; if (issues != 2) begin n_fail++; $display("FAIL credit_issues got %0d expected 2", issues); end
        n_checks++; if (infl_b !== 3'd2) begin n_fail++; $display("FAIL credit_inflight got %0d expected 2", infl_b); end
        man_valid = 1'b1; man_id = 4'b0000;
        @(negedge i_clk);
        man_valid = 1'b0;
        #1;
        n_checks++; if (infl_b !== 3'd1) begin n_fail++; $display("FAIL credit_release_inflight got %0d expected 1", infl_b); end
        n_checks++; if (ready_b !== 4'b0001) begin n_fail++; $display("FAIL credit_regrant got %b expected 0001", ready_b); end
        @(negedge i_clk);
        #1;
        n_checks++; if (ready_b !== 4'b0000) begin n_fail++; $display("FAIL credit_single_regrant got %b expected 0000", ready_b); end
        @(negedge i_clk);
        #1;
        n_checks++; if (infl_b !== 3'd2) begin n_fail++; $display("FAIL credit_refill got %0d expected 2", infl_b); end
        n_checks++; if (ready_b !== 4'b0000) begin n_fail++; $display("FAIL credit_hold got %b expected 0000", ready_b); end
        i_req_valid = '0;
    endtask

    task automatic test_drain;
        int rsps;
        do_reset(1'b1);
        i_req_mac = {48'hDD, 48'hCC, 48'hBB, 48'hAA};
        i_req_tag = 8'b00_00_00_00;
        i_req_valid = 4'b1111;
        rsps = 0;
        repeat (3) @(negedge i_clk);
        i_pause = 1'b1;
        #1;
        n_checks++; if (ready_a !== 4'b0000) begin n_fail++; $display("FAIL drain_same_cycle_ready got %b expected 0000", ready_a); end
        n_checks++; if ({infl_a, cv_a} !== {3'd2, 1'b1}) begin n_fail++; $display("FAIL drain_outstanding got %0d+%b expected 2+1", infl_a, cv_a); end
        for (int c = 4; c <= 6; c++) begin
            @(negedge i_clk);
            #1;
            if (rspv_a != 4'b0000) rsps++;
            n_checks++; if ({ready_a, paused_a} !== 5'b0000_0) begin n_fail++; $display("FAIL drain_wait c=%0d got ready %b paused %b expected 0000 0", c, ready_a, paused_a); end
        end
        n_checks++; if (infl_a !== 3'd0) begin n_fail++; $display("FAIL drain_empty got %0d expected 0", infl_a); end
        n_checks++; if (rsps != 3) begin n_fail++; $display("FAIL drain_rsp_count got %0d expected 3", rsps); end
        @(negedge i_clk);
        #1;
        n_checks++; if (paused_a !== 1'b1) begin n_fail++; $display("FAIL drain_paused got %b expected 1", paused_a); end
        @(negedge i_clk);
        i_pause = 1'b0;
        #1;
        n_checks++; if (ready_a !== 4'b0000) begin n_fail++; $display("FAIL resume_early got %b expected 0000", ready_a); end
        @(negedge i_clk);
        #1;
        n_checks++; if (ready_a !== 4'b1000) begin n_fail++; $display("FAIL resume_ready got %b expected 1000", ready_a); end
        n_checks++; if (paused_a !== 1'b0) begin n_fail++; $display("FAIL resume_paused got %b expected 0", paused_a); end
        i_req_valid = '0;
    endtask

    task automatic test_orphan;
        do_reset(1'b0);
        man_valid = 1'b1; man_id = 4'b1110; man_outport = 3'd5; man_seek = 2'd3;
        @(negedge i_clk);
        man_valid = 1'b0;
        #1;
        n_checks++; if (orph_a !== 1'b1) begin n_fail++; $display("FAIL orphan_flag got %b expected 1", orph_a); end
        n_checks++; if (infl_a !== 3'd0) begin n_fail++; $display("FAIL orphan_inflight got %0d expected 0", infl_a); end
        n_checks++; if (rspv_a !== 4'b1000) begin n_fail++; $display("FAIL orphan_rsp_valid got %b expected 1000", rspv_a); end
        n_checks++; if ({rspo_a[11:9], rsps_a[7:6], rspt_a[7:6]} !== {3'd5, 2'd3, 2'd2}) begin n_fail++; $display("FAIL orphan_rsp_fields got %b expected 1011110", {rspo_a[11:9], rsps_a[7:6], rspt_a[7:6]}); end
        repeat (3) @(negedge i_clk);
        #1;
        n_checks++; if ({orph_a, rspv_a} !== 5'b1_0000) begin n_fail++; $display("FAIL orphan_sticky got %b expected 10000", {orph_a, rspv_a}); end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        i_req_mac = '0;
        i_req_tag = '0;
        test_reset;
        test_single;
        test_fairness;
        test_credit;
        test_drain;
        test_orphan;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lookup_arbiter.md
Name: lookup_arbiter

Overview:
- Shares one server/ToR MAC lookup engine between four requesters (downlink/uplink rx parsers), using round-robin arbitration.
- The engine's check interface takes mac, 4-bit id and valid, and returns outport, seek_flag, id and result_valid two cycles after issue.
- The arbiter tags each issue with the requester index, caps in-flight lookups, and routes each result back to its requester by id.
- It also provides a pause/drain handshake so slot control can change i_cur_connect_tor only while no lookup is in flight.

Parameters:
- P_REQ_NUM, 4, number of requesters. Fixed at 4 because the index occupies check_id[3:2].
- P_MAX_INFLIGHT, 4, maximum outstanding lookups (1..7).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_enable  in  1  one-cycle start pulse, latched
- i_pause  in  1  level; request to stop issuing and drain
- o_paused  out  1  high while paused with zero in flight
- i_req_valid  in  4  per-requester lookup request
- i_req_mac  in  192  requester k uses bits [48k+47:48k]
- i_req_tag  in  8  requester k uses 2-bit tag at [2k+1:2k]
- o_req_ready  out  4  one-hot grant, combinational
- o_check_mac  out  48  to engine
- o_check_id  out  4  {requester index[1:0], tag[1:0]}
- o_check_valid  out  1  to engine
- i_result_valid  in  1  from engine
- i_check_id  in  4  from engine
- i_outport  in  3  from engine
- i_seek_flag  in  2  from engine
- o_rsp_valid  out  4  per-requester result strobe
- o_rsp_outport  out  12  3 bits per requester
- o_rsp_seek_flag  out  8  2 bits per requester
- o_rsp_tag  out  8  2 bits per requester
- o_inflight  out  3  current outstanding count
- o_err_orphan  out  1  sticky, result received with zero outstanding

Behaviour:
- Reset values:
  - State is S_IDLE; round-robin pointer is 0.
  - All outputs are 0, including o_paused, o_inflight and o_err_orphan.
- States:
  - S_IDLE → S_RUN on i_enable (the pulse is latched).
  - S_RUN → S_DRAIN when i_pause=1.
  - S_DRAIN → S_RUN when i_pause=0.
  - S_DRAIN → S_PAUSED when i_pause=1, inflight==0 and o_check_valid==0.
  - S_PAUSED → S_RUN when i_pause=0.
  - o_paused=1 only in S_PAUSED.
- Grant:
  - Only in S_RUN, and only when (inflight + o_check_valid) < P_MAX_INFLIGHT.
  - o_req_ready is one-hot: the first valid requester searching from the pointer upward, with wrap-around.
  - Grant is combinational from i_req_valid, so the handshake completes in the same cycle.
  - After a grant to k, the pointer becomes (k+1) mod 4.
  - At most one grant per cycle. A requester keeps valid and mac stable until ready.
- Issue:
  - Registered; the cycle after a grant, o_check_valid=1, o_check_mac = granted mac, o_check_id = {k, tag_k}.
  - Otherwise o_check_valid=0 and mac/id hold their previous values.
- Inflight:
  - +1 when o_check_valid=1; -1 when i_result_valid=1; unchanged when both occur.
  - Saturates at 0; if a result arrives at 0, o_err_orphan is set and only clears on reset.
- Response:
  - Registered; the cycle after i_result_valid, o_rsp_valid[i_check_id[3:2]] = 1.
  - The matching outport, seek_flag and tag slices are loaded from i_outport, i_seek_flag and i_check_id[1:0].
  - Other slices hold their values. o_rsp_valid is a one-cycle pulse.
- End-to-end latency with the 2-cycle engine: grant → rsp_valid = 4 cycles.
- Pause asserted in the same cycle as a pending grant in S_RUN: the grant is suppressed, because the state check uses the registered state and i_pause combinationally.
- A result arriving during S_DRAIN or S_PAUSED is still delivered.
- i_enable while already running has no effect.
- Reset mid-operation clears all state. The engine is reset by the same i_rst, so no stale results are expected.

Test Plan:
- Single request: after enable, req 2 valid with mac 8DBC5C4A0102 and tag 1.
  - ready[2] rises the same cycle; next cycle check_valid=1 with id 4'b1001.
  - A result (id 9, outport 1, seek 1) returns 2 cycles later; rsp_valid[2] pulses the following cycle with outport 1, seek 1, tag 1.
- Fairness: all four requesters hold valid continuously → grants cycle 0,1,2,3,0,… one per cycle. Each requester gets 25% over 40 cycles.
- Credit cap: P_MAX_INFLIGHT=2 with engine results held off → only 2 issues occur, ready stays 0, o_inflight=2. Releasing one result allows exactly one new grant.
- Drain: assert i_pause with 3 in flight → no further grants; o_paused rises the cycle after the last result retires (inflight=0). Deasserting pause resumes grants the next cycle.
- Simultaneous issue and retire: continuous traffic at a steady state → o_inflight stays constant.
- Orphan: inject i_result_valid while inflight=0 → o_err_orphan=1 sticky, o_inflight stays 0, and the rsp still pulses for the decoded index.
